// File: rtl/aes_mode_ctrl_if.sv
// Stream, configuration and AES-core handshake bundle for aes_mode_ctrl.
// The slave modport is the controller's view; master is the surrounding system.
interface aes_mode_ctrl_if;
   logic         cfg_load;
   logic [127:0] cfg_key;
   logic [127:0] cfg_iv;
   logic [1:0]   cfg_mode;
   logic         cfg_dir;
   logic         s_valid;
   logic         s_ready;
   logic [127:0] s_data;
   logic         m_valid;
   logic         m_ready;
   logic [127:0] m_data;
   logic         core_en;
   logic [127:0] core_key;
   logic         core_slt;
   logic         core_data_in_valid;
   logic [127:0] core_data_in;
   logic         core_rk_ready;
   logic         core_data_out_valid;
   logic [127:0] core_data_out;
   logic         busy;
   logic         err;

   modport slave (
      input  cfg_load, cfg_key, cfg_iv, cfg_mode, cfg_dir, s_valid, s_data, m_ready,
             core_rk_ready, core_data_out_valid, core_data_out,
      output s_ready, m_valid, m_data, core_en, core_key, core_slt, core_data_in_valid,
             core_data_in, busy, err
   );

   modport master (
      output cfg_load, cfg_key, cfg_iv, cfg_mode, cfg_dir, s_valid, s_data, m_ready,
             core_rk_ready, core_data_out_valid, core_data_out,
      input  s_ready, m_valid, m_data, core_en, core_key, core_slt, core_data_in_valid,
             core_data_in, busy, err
   );
endinterface

// File: rtl/aes_mode_ctrl.sv
// ECB/CBC/CTR mode controller around a single AES128 core: input block FIFO,
// chaining register, key-expansion sequencing and timeout supervision.
module aes_mode_ctrl #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CTR_W      = 32,
   parameter int unsigned TIMEOUT    = 255
) (
   input logic            clk,
   input logic            rstn,
   aes_mode_ctrl_if.slave bus
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam logic [1:0] ModeEcb  = 2'b00;
   localparam logic [1:0] ModeCbc  = 2'b01;
   localparam logic [1:0] ModeCtr  = 2'b10;
   localparam logic [1:0] ModeRsvd = 2'b11;

   typedef enum logic [2:0] {StIdle, StKeyx, StReady, StIssue, StWait, StOut} state_e;

   state_e         state_q, state_d;
   logic [127:0]   key_q, key_d, chain_q, chain_d, din_q, din_d;
   logic [127:0]   blk_q, blk_d, mdata_q, mdata_d;
   logic [1:0]     mode_q, mode_d;
   logic           dir_q, dir_d, err_q, err_d;
   logic [TW-1:0]  tmo_q, tmo_d;
   logic           tmo_hit;

   logic [127:0]   fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_addr;
   logic [AW:0]    count_q, count_d;
   logic           s_ready_q, push, pop, flush, empty, cfg_ok, cfg_take;
   logic [127:0]   head;

   assign empty    = (count_q == '0);
   assign head     = fifo_mem[rd_ptr_q];
   assign push     = bus.s_valid && s_ready_q;
   assign wr_addr  = flush ? '0 : wr_ptr_q;
   assign cfg_ok   = (state_q == StIdle || state_q == StReady) && empty;
   assign cfg_take = bus.cfg_load && cfg_ok;
   assign tmo_hit  = (tmo_q == TW'(TIMEOUT - 1));

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
         count_d  = count_q - (AW + 1)'(1);
      end
      if (push) begin
         wr_ptr_d = wr_ptr_d + AW'(1);
         count_d  = count_d + (AW + 1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_addr] <= bus.s_data;
   end

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      mode_d  = mode_q;
      dir_d   = dir_q;
      chain_d = chain_q;
      din_d   = din_q;
      blk_d   = blk_q;
      mdata_d = mdata_q;
      err_d   = err_q;
      tmo_d   = '0;
      pop     = 1'b0;
      flush   = 1'b0;
      if (bus.cfg_load && !cfg_ok) err_d = 1'b1;
      case (state_q)
         StIdle, StReady: begin
            if (cfg_take) begin
               if (bus.cfg_mode == ModeRsvd) begin
                  err_d   = 1'b1;
                  state_d = StIdle;
               end else begin
                  err_d   = 1'b0;
                  key_d   = bus.cfg_key;
                  mode_d  = bus.cfg_mode;
                  dir_d   = bus.cfg_dir;
                  chain_d = bus.cfg_iv;
                  state_d = StKeyx;
               end
            end else if (state_q == StReady && !empty) begin
               // Core input is prepared here so it is already stable during ISSUE.
               unique case (mode_q)
                  ModeCbc: din_d = dir_q ? head : (head ^ chain_q);
                  ModeCtr: din_d = chain_q;
                  default: din_d = head;
               endcase
               state_d = StIssue;
            end
         end
         StKeyx: begin
            if (bus.core_rk_ready) begin
               state_d = StReady;
            end else if (tmo_hit) begin
               err_d   = 1'b1;
               flush   = 1'b1;
               state_d = StIdle;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         StIssue: begin
            pop   = 1'b1;
            blk_d = head;
            if (mode_q == ModeCtr) chain_d[CTR_W-1:0] = chain_q[CTR_W-1:0] + CTR_W'(1);
            state_d = StWait;
         end
         StWait: begin
            if (bus.core_data_out_valid) begin
               unique case (mode_q)
                  ModeCbc: begin
                     // Decrypt chains off the previous ciphertext held in blk_q since ISSUE.
                     mdata_d = dir_q ? (bus.core_data_out ^ chain_q) : bus.core_data_out;
                     chain_d = dir_q ? blk_q : bus.core_data_out;
                  end
                  ModeCtr: mdata_d = bus.core_data_out ^ blk_q;
                  ModeEcb: mdata_d = bus.core_data_out;
                  default: mdata_d = bus.core_data_out;
               endcase
               state_d = StOut;
            end else if (tmo_hit) begin
               err_d   = 1'b1;
               flush   = 1'b1;
               state_d = StIdle;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         StOut: begin
            if (bus.m_ready) state_d = StReady;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= StIdle;
         key_q     <= '0;
         mode_q    <= ModeEcb;
         dir_q     <= 1'b0;
         chain_q   <= '0;
         din_q     <= '0;
         blk_q     <= '0;
         mdata_q   <= '0;
         err_q     <= 1'b0;
         tmo_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         s_ready_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         key_q     <= key_d;
         mode_q    <= mode_d;
         dir_q     <= dir_d;
         chain_q   <= chain_d;
         din_q     <= din_d;
         blk_q     <= blk_d;
         mdata_q   <= mdata_d;
         err_q     <= err_d;
         tmo_q     <= tmo_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         // Registered so the port reads 0 while in reset; it tracks !full afterwards.
         s_ready_q <= (count_d != (AW + 1)'(FIFO_DEPTH));
      end
   end

   assign bus.s_ready            = s_ready_q;
   assign bus.m_valid            = (state_q == StOut);
   assign bus.m_data             = mdata_q;
   assign bus.core_en            = (state_q == StKeyx);
   assign bus.core_key           = key_q;
   assign bus.core_slt           = (mode_q == ModeCtr) ? 1'b0 : dir_q;
   assign bus.core_data_in_valid = (state_q == StIssue);
   assign bus.core_data_in       = din_q;
   assign bus.busy               = !(state_q == StIdle || state_q == StReady) || !empty;
   assign bus.err                = err_q;

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// Bench for aes_mode_ctrl: a behavioural AES core stub answering known AES128 vectors
// (other inputs return data^key), a vector table, and directed corner-case sequences.
module tb_aes_mode_ctrl;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   aes_mode_ctrl_if bus ();

   aes_mode_ctrl #(
      .FIFO_DEPTH(4),
      .CTR_W     (32),
      .TIMEOUT   (255)
   ) dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus)
   );

   localparam logic [127:0] K0   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT0  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] IV0  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P1   = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] C1   = 128'h7649abac8119b246cee98e9b12e9197d;
   localparam logic [127:0] P2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
   localparam logic [127:0] C2   = 128'h5086cb9b507219ee95db113a917678b2;
   localparam logic [127:0] IVC  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
   localparam logic [127:0] KS1  = 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
   localparam logic [127:0] CTR1 = 128'h874d6191b620e3261bef6864990db6ce;
   localparam logic [127:0] IVW  = 128'ha5a5a5a55a5a5a5a0f0f0f0fffffffff;
   localparam logic [127:0] IVW2 = 128'ha5a5a5a55a5a5a5a0f0f0f0f00000000;

   int n_tests = 0;
   int n_fail  = 0;

   logic [127:0] kt_key [5];
   logic [127:0] kt_din [5];
   logic [127:0] kt_out [5];
   logic         kt_slt [5];

   function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] d,
                                            input logic s);
      logic [127:0] r;
      r = d ^ k;
      for (int i = 0; i < 5; i++)
         if (kt_key[i] == k && kt_din[i] == d && kt_slt[i] == s) r = kt_out[i];
      return r;
   endfunction

   // Core stub: round keys 3 cycles after core_en, result 3 cycles after data_in_valid.
   logic         rk_block = 1'b0;
   logic         out_block = 1'b0;
   logic [1:0]   rk_cnt;
   logic         pend, lat;
   logic [127:0] cap_din, cap_key;
   logic         cap_slt;
   int           n_issue = 0;
   logic [127:0] din_log [16];
   logic         slt_log [16];

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bus.core_rk_ready       <= 1'b0;
         bus.core_data_out_valid <= 1'b0;
         bus.core_data_out       <= '0;
         rk_cnt                  <= '0;
         pend                    <= 1'b0;
         lat                     <= 1'b0;
      end else begin
         bus.core_rk_ready       <= 1'b0;
         bus.core_data_out_valid <= 1'b0;
         if (bus.core_en && !rk_block && !bus.core_rk_ready) begin
            if (rk_cnt == 2'd2) begin
               bus.core_rk_ready <= 1'b1;
               rk_cnt            <= '0;
            end else begin
               rk_cnt <= rk_cnt + 2'd1;
            end
         end else if (!bus.core_en) begin
            rk_cnt <= '0;
         end
         if (bus.core_data_in_valid) begin
            pend                  <= 1'b1;
            lat                   <= 1'b0;
            cap_din               <= bus.core_data_in;
            cap_key               <= bus.core_key;
            cap_slt               <= bus.core_slt;
            din_log[n_issue % 16] <= bus.core_data_in;
            slt_log[n_issue % 16] <= bus.core_slt;
            n_issue               <= n_issue + 1;
         end else if (pend && !out_block) begin
            if (lat) begin
               bus.core_data_out_valid <= 1'b1;
               bus.core_data_out       <= core_fn(cap_key, cap_din, cap_slt);
               pend                    <= 1'b0;
            end else begin
               lat <= 1'b1;
            end
         end
      end
   end

   typedef struct {
      logic [1:0]   mode;
      logic         dir;
      logic [127:0] key;
      logic [127:0] iv;
      logic [127:0] blk;
      logic [127:0] exp_din;
      logic [127:0] exp_out;
      logic         exp_slt;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic expire(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   task automatic load_cfg(input logic [1:0] mode, input logic dir, input logic [127:0] key,
                           input logic [127:0] iv);
      @(negedge clk);
      bus.cfg_load = 1'b1;
      bus.cfg_mode = mode;
      bus.cfg_dir  = dir;
      bus.cfg_key  = key;
      bus.cfg_iv   = iv;
      @(negedge clk);
      bus.cfg_load = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int c = 0;
      while (bus.busy && c < 400) begin
         @(negedge clk);
         c++;
      end
      if (c >= 400) expire(name);
   endtask

   task automatic push_blk(input logic [127:0] blk);
      bit ok = 1'b0;
      @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_data  = blk;
      for (int c = 0; c < 200 && !ok; c++) begin
         if (bus.s_ready) begin
            @(posedge clk);
            ok = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      #1 bus.s_valid = 1'b0;
      if (!ok) expire("push");
   endtask

   task automatic get_out(input logic [127:0] exp, input string name);
      bit got = 1'b0;
      for (int c = 0; c < 300 && !got; c++) begin
         @(negedge clk);
         if (bus.m_valid) begin
            check(name, bus.m_data, exp);
            bus.m_ready = 1'b1;
            @(posedge clk);
            #1 bus.m_ready = 1'b0;
            got = 1'b1;
         end
      end
      if (!got) expire(name);
   endtask

   initial begin
      int   base;
      int   cyc;
      bit   extra;
      logic [127:0] b;

      kt_key[0] = K0; kt_din[0] = PT0;     kt_slt[0] = 1'b0; kt_out[0] = CT0;
      kt_key[1] = K0; kt_din[1] = CT0;     kt_slt[1] = 1'b1; kt_out[1] = PT0;
      kt_key[2] = K1; kt_din[2] = P1 ^ IV0; kt_slt[2] = 1'b0; kt_out[2] = C1;
      kt_key[3] = K1; kt_din[3] = P2 ^ C1;  kt_slt[3] = 1'b0; kt_out[3] = C2;
      kt_key[4] = K1; kt_din[4] = IVC;     kt_slt[4] = 1'b0; kt_out[4] = KS1;

      vecs[0] = '{mode: 2'b00, dir: 1'b0, key: K0, iv: 128'h0, blk: PT0,
                  exp_din: PT0, exp_out: CT0, exp_slt: 1'b0};
      vecs[1] = '{mode: 2'b00, dir: 1'b1, key: K0, iv: 128'h0, blk: CT0,
                  exp_din: CT0, exp_out: PT0, exp_slt: 1'b1};
      vecs[2] = '{mode: 2'b01, dir: 1'b0, key: K1, iv: IV0, blk: P1,
                  exp_din: 128'h6bc0bce12a459991e134741a7f9e1925, exp_out: C1, exp_slt: 1'b0};
      vecs[3] = '{mode: 2'b10, dir: 1'b1, key: K1, iv: IVC, blk: P1,
                  exp_din: IVC, exp_out: CTR1, exp_slt: 1'b0};
      vecs[4] = '{mode: 2'b01, dir: 1'b1, key: 128'h0, iv: {16{8'h22}}, blk: {16{8'h11}},
                  exp_din: {16{8'h11}}, exp_out: {16{8'h33}}, exp_slt: 1'b1};
      vecs[5] = '{mode: 2'b00, dir: 1'b0, key: {16{8'hff}},
                  iv: 128'h0, blk: 128'h0123456789abcdeffedcba9876543210,
                  exp_din: 128'h0123456789abcdeffedcba9876543210,
                  exp_out: 128'hfedcba98765432100123456789abcdef, exp_slt: 1'b0};

      bus.cfg_load = 1'b0; bus.cfg_key = '0; bus.cfg_iv = '0; bus.cfg_mode = '0;
      bus.cfg_dir  = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;

      // Reset values
      #12;
      check("rst_ctl", {bus.s_ready, bus.m_valid, bus.core_en, bus.core_slt,
                        bus.core_data_in_valid, bus.busy, bus.err}, '0);
      check("rst_data", bus.m_data | bus.core_key | bus.core_data_in, '0);
      @(negedge clk);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      check("s_ready_after_rst", bus.s_ready, 1'b1);

      // Single-block vector table
      for (int i = 0; i < 6; i++) begin
         load_cfg(vecs[i].mode, vecs[i].dir, vecs[i].key, vecs[i].iv);
         wait_idle($sformatf("vec%0d_keyx", i));
         check($sformatf("vec%0d_key", i), bus.core_key, vecs[i].key);
         base = n_issue;
         push_blk(vecs[i].blk);
         get_out(vecs[i].exp_out, $sformatf("vec%0d_out", i));
         check($sformatf("vec%0d_din", i), din_log[base % 16], vecs[i].exp_din);
         check($sformatf("vec%0d_slt", i), {127'h0, slt_log[base % 16]},
               {127'h0, vecs[i].exp_slt});
      end
      @(negedge clk);
      check("m_data_hold", bus.m_data, vecs[5].exp_out);

      // CBC encrypt, two chained blocks
      load_cfg(2'b01, 1'b0, K1, IV0);
      wait_idle("cbc2e_keyx");
      push_blk(P1);
      push_blk(P2);
      get_out(C1, "cbc2e_out1");
      get_out(C2, "cbc2e_out2");

      // CBC decrypt, two blocks: second output chains off first ciphertext
      load_cfg(2'b01, 1'b1, 128'h0, {16{8'h22}});
      wait_idle("cbc2d_keyx");
      push_blk({16{8'h11}});
      push_blk({16{8'h44}});
      get_out({16{8'h33}}, "cbc2d_out1");
      get_out({16{8'h55}}, "cbc2d_out2");

      // CTR low-word wrap
      load_cfg(2'b10, 1'b0, 128'h0, IVW);
      wait_idle("ctrw_keyx");
      base = n_issue;
      push_blk(128'h0);
      push_blk(128'h0);
      get_out(IVW, "ctrw_out1");
      get_out(IVW2, "ctrw_out2");
      check("ctrw_din1", din_log[base % 16], IVW);
      check("ctrw_din2", din_log[(base + 1) % 16], IVW2);

      // FIFO fill with output stalled, then drain in order
      load_cfg(2'b00, 1'b0, 128'h0, 128'h0);
      wait_idle("fifo_keyx");
      for (int i = 0; i < 5; i++) begin
         b = {4{32'hc0de0000 + 32'(i)}};
         push_blk(b);
      end
      repeat (3) @(negedge clk);
      check("fifo_full", bus.s_ready, 1'b0);
      bus.s_valid = 1'b1;
      bus.s_data  = {16{8'hee}};
      repeat (3) @(negedge clk);
      check("fifo_full_hold", bus.s_ready, 1'b0);
      bus.s_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         b = {4{32'hc0de0000 + 32'(i)}};
         get_out(b, $sformatf("fifo_out%0d", i));
      end
      extra = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (bus.m_valid) extra = 1'b1;
      end
      check("fifo_no_extra", {127'h0, extra}, 128'h0);

      // Reserved mode
      load_cfg(2'b11, 1'b0, K0, 128'h0);
      repeat (2) @(negedge clk);
      check("rsvd_err", bus.err, 1'b1);
      check("rsvd_idle", {bus.busy, bus.core_en}, 2'b00);

      // Accepted load clears err; load during key expansion is rejected
      load_cfg(2'b00, 1'b0, K0, 128'h0);
      check("err_clear", bus.err, 1'b0);
      load_cfg(2'b00, 1'b0, K0, 128'h0);
      check("cfg_busy_err", bus.err, 1'b1);
      wait_idle("busy_keyx");
      check("err_sticky", bus.err, 1'b1);

      // Key-expansion timeout
      rk_block = 1'b1;
      load_cfg(2'b00, 1'b0, K0, 128'h0);
      check("err_clear_keyx", bus.err, 1'b0);
      cyc = 0;
      while (bus.busy && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      check("keyx_tmo_err", bus.err, 1'b1);
      check("keyx_tmo_len", {127'h0, (cyc >= 250 && cyc < 400)}, 128'h1);
      rk_block = 1'b0;

      // Result timeout in WAIT flushes the FIFO
      load_cfg(2'b00, 1'b0, K0, 128'h0);
      wait_idle("tmo_keyx");
      check("err_clear2", bus.err, 1'b0);
      out_block = 1'b1;
      push_blk(PT0);
      push_blk(CT0);
      cyc = 0;
      while (!bus.err && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      check("wait_tmo_err", bus.err, 1'b1);
      check("wait_tmo_len", {127'h0, (cyc >= 200 && cyc < 400)}, 128'h1);
      @(negedge clk);
      check("wait_tmo_flush", {bus.busy, bus.core_en, bus.m_valid}, 3'b000);
      out_block = 1'b0;

      // Reset while waiting on the core
      load_cfg(2'b00, 1'b0, K0, 128'h0);
      wait_idle("rstw_keyx");
      out_block = 1'b1;
      push_blk(PT0);
      repeat (5) @(negedge clk);
      check("rstw_busy", bus.busy, 1'b1);
      rstn = 1'b0;
      #1;
      check("rstw_ctl", {bus.s_ready, bus.m_valid, bus.core_en, bus.core_slt,
                         bus.core_data_in_valid, bus.busy, bus.err}, '0);
      check("rstw_data", bus.m_data | bus.core_key | bus.core_data_in, '0);
      @(negedge clk);
      rstn = 1'b1;
      out_block = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
